pkt_frame_ctrl: RTL and testbench

//  Sequencing controller for the single-lane packet identifier datapath. Consumes the

---
 rtl/pkt_frame_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_pkt_frame_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_frame_ctrl.sv
// Packet framing sequencer: tracks STP/SDP framing on a byte/K stream and emits
// registered payload bytes, start/end markers, lengths, framing errors and statistics.
module pkt_frame_ctrl #(
  parameter int MAX_TLP_LEN = 4096,
  parameter int DLLP_LEN    = 6,
  parameter int LEN_W       = 13,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [7:0]       data_in,
  input  logic             DK,
  input  logic             stat_clr,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [1:0]       tlp_or_dllp_out,
  output logic             pkt_start,
  output logic             pkt_end,
  output logic             pkt_good,
  output logic [LEN_W-1:0] pkt_len,
  output logic             err_framing,
  output logic             err_length,
  output logic [CNT_W-1:0] good_tlp_cnt,
  output logic [CNT_W-1:0] good_dllp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state_o
);

  // Handshake: valid qualifies data_in/DK for one cycle; there is no ready,
  // the block accepts every valid symbol and holds all state when valid=0.

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_PAD = 8'hF7;

  localparam logic [LEN_W-1:0] TLP_MAX  = LEN_W'(MAX_TLP_LEN);
  localparam logic [LEN_W-1:0] DLLP_EXP = LEN_W'(DLLP_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_TLP  = 2'd1,
    IN_DLLP = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [1:0]       kind_q, kind_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             good_q, good_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             errf_q, errf_d;
  logic             errl_q, errl_d;
  logic [CNT_W-1:0] tlp_cnt_q, tlp_cnt_d;
  logic [CNT_W-1:0] dllp_cnt_q, dllp_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             in_pkt;
  logic [LEN_W-1:0] limit;

  function automatic logic [1:0] kind_of(state_t s);
    case (s)
      IN_TLP:  kind_of = 2'b01;
      IN_DLLP: kind_of = 2'b10;
      default: kind_of = 2'b00;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c, logic en);
    sat_inc = (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
  endfunction

  assign in_pkt = (state_q == IN_TLP) || (state_q == IN_DLLP);
  assign limit  = (state_q == IN_TLP) ? TLP_MAX : DLLP_EXP;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = 8'h00;
    start_d     = 1'b0;
    end_d       = 1'b0;
    good_d      = 1'b0;
    len_d       = '0;
    errf_d      = 1'b0;
    errl_d      = 1'b0;

    if (valid) begin
      if (!DK) begin
        if (in_pkt) begin
          if (cnt_q == limit) begin
            end_d   = 1'b1;
            len_d   = cnt_q;
            errl_d  = 1'b1;
            state_d = DISCARD;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = data_in;
            cnt_d       = cnt_q + LEN_W'(1);
          end
        end
      end else begin
        case (data_in)
          K_STP, K_SDP: begin
            // A start inside an open packet aborts it and opens the new one at once.
            if (in_pkt) begin
              end_d  = 1'b1;
              len_d  = cnt_q;
              errf_d = 1'b1;
            end
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = (data_in == K_STP) ? IN_TLP : IN_DLLP;
          end
          K_END: begin
            if (state_q == IN_TLP) begin
              end_d  = 1'b1;
              good_d = 1'b1;
              len_d  = cnt_q;
            end else if (state_q == IN_DLLP) begin
              end_d  = 1'b1;
              good_d = (cnt_q == DLLP_EXP);
              errl_d = (cnt_q != DLLP_EXP);
              len_d  = cnt_q;
            end else if (state_q == IDLE) begin
              errf_d = 1'b1;
            end
            state_d = IDLE;
          end
          K_EDB: begin
            if (in_pkt) begin
              end_d  = 1'b1;
              len_d  = cnt_q;
              errf_d = (state_q == IN_DLLP);
            end else if (state_q == IDLE) begin
              errf_d = 1'b1;
            end
            state_d = IDLE;
          end
          K_PAD: begin
          end
          default: begin
            if (in_pkt) begin
              end_d   = 1'b1;
              len_d   = cnt_q;
              errf_d  = 1'b1;
              state_d = DISCARD;
            end
          end
        endcase
      end
    end

    // On a plain close the kind output still names the packet being closed.
    kind_d = kind_of(state_d);
    if (end_d && !start_d) kind_d = kind_of(state_q);

    tlp_cnt_d  = sat_inc(tlp_cnt_q, end_d && good_d && (state_q == IN_TLP));
    dllp_cnt_d = sat_inc(dllp_cnt_q, end_d && good_d && (state_q == IN_DLLP));
    err_cnt_d  = sat_inc(err_cnt_q, errf_d || errl_d);
    if (stat_clr) begin
      tlp_cnt_d  = '0;
      dllp_cnt_d = '0;
      err_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      kind_q      <= 2'b00;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      good_q      <= 1'b0;
      len_q       <= '0;
      errf_q      <= 1'b0;
      errl_q      <= 1'b0;
      tlp_cnt_q   <= '0;
      dllp_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      kind_q      <= kind_d;
      start_q     <= start_d;
      end_q       <= end_d;
      good_q      <= good_d;
      len_q       <= len_d;
      errf_q      <= errf_d;
      errl_q      <= errl_d;
      tlp_cnt_q   <= tlp_cnt_d;
      dllp_cnt_q  <= dllp_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign tlp_or_dllp_out = kind_q;
  assign pkt_start       = start_q;
  assign pkt_end         = end_q;
  assign pkt_good        = good_q;
  assign pkt_len         = len_q;
  assign err_framing     = errf_q;
  assign err_length      = errl_q;
  assign good_tlp_cnt    = tlp_cnt_q;
  assign good_dllp_cnt   = dllp_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_pkt_frame_ctrl.sv
// Bench for pkt_frame_ctrl: directed vector table, hand sequences for reset and
// counter saturation, then random symbols against a payload-queue model.
module tb_pkt_frame_ctrl;

  localparam int MAXL  = 8;
  localparam int DLLPL = 6;
  localparam int LW    = 13;
  localparam int CW    = 4;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDK = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] UNK = 8'h1C;

  logic          clk = 1'b0;
  logic          rst, valid, DK, stat_clr;
  logic [7:0]    data_in;
  logic          out_valid, pkt_start, pkt_end, pkt_good, err_framing, err_length;
  logic [7:0]    out_data;
  logic [1:0]    tlp_or_dllp_out, dbg_state;
  logic [LW-1:0] pkt_len;
  logic [CW-1:0] good_tlp_cnt, good_dllp_cnt, err_cnt;

  int total = 0;
  int bad   = 0;

  pkt_frame_ctrl #(.MAX_TLP_LEN(MAXL), .DLLP_LEN(DLLPL), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .data_in(data_in), .DK(DK), .stat_clr(stat_clr),
    .out_valid(out_valid), .out_data(out_data), .tlp_or_dllp_out(tlp_or_dllp_out),
    .pkt_start(pkt_start), .pkt_end(pkt_end), .pkt_good(pkt_good), .pkt_len(pkt_len),
    .err_framing(err_framing), .err_length(err_length), .good_tlp_cnt(good_tlp_cnt),
    .good_dllp_cnt(good_dllp_cnt), .err_cnt(err_cnt), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ov;
    logic [7:0]    od;
    logic [1:0]    kind;
    logic          st, en, gd;
    logic [LW-1:0] len;
    logic          ef, el;
    int            tlp, dllp, err;
  } exp_t;

  typedef struct {
    logic       v, k;
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v, logic k, logic [7:0] d, logic ov, logic [1:0] kind,
                              logic st, logic en, logic gd, int len, logic ef, logic el);
    vec_t r;
    r.v = v; r.k = k; r.d = d;
    r.e = '{default: '0};
    r.e.ov = ov; r.e.od = ov ? d : 8'h00; r.e.kind = kind;
    r.e.st = st; r.e.en = en; r.e.gd = gd; r.e.len = LW'(len);
    r.e.ef = ef; r.e.el = el;
    return r;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic check_outs(string tag, exp_t e, bit cnts);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
    if (e.ov) chk({tag, ".out_data"}, 32'(out_data), 32'(e.od));
    chk({tag, ".kind"}, 32'(tlp_or_dllp_out), 32'(e.kind));
    chk({tag, ".pkt_start"}, 32'(pkt_start), 32'(e.st));
    chk({tag, ".pkt_end"}, 32'(pkt_end), 32'(e.en));
    chk({tag, ".pkt_good"}, 32'(pkt_good), 32'(e.gd));
    chk({tag, ".pkt_len"}, 32'(pkt_len), 32'(e.len));
    chk({tag, ".err_framing"}, 32'(err_framing), 32'(e.ef));
    chk({tag, ".err_length"}, 32'(err_length), 32'(e.el));
    if (cnts) begin
      chk({tag, ".good_tlp_cnt"}, 32'(good_tlp_cnt), 32'(e.tlp));
      chk({tag, ".good_dllp_cnt"}, 32'(good_dllp_cnt), 32'(e.dllp));
      chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e.err));
    end
  endtask

  task automatic drive(logic v, logic k, logic [7:0] d, logic clr);
    valid = v; DK = k; data_in = d; stat_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: open packet kind plus a queue of accepted payload bytes.
  int         m_kind;   // 0 none, 1 TLP, 2 DLLP
  bit         m_disc;
  logic [7:0] m_pay[$];
  int         m_tlp, m_dllp, m_err;
  localparam int CMAX = (1 << CW) - 1;

  task automatic model(logic v, logic k, logic [7:0] d, logic clr, output exp_t e);
    int closing;
    int lim;
    e = '{default: '0};
    closing = m_kind;
    if (v) begin
      if (!k) begin
        if (m_kind != 0) begin
          lim = (m_kind == 1) ? MAXL : DLLPL;
          if (m_pay.size() == lim) begin
            e.en = 1; e.len = LW'(m_pay.size()); e.el = 1;
            m_kind = 0; m_disc = 1;
          end else begin
            e.ov = 1; e.od = d; m_pay.push_back(d);
          end
        end
      end else if (d == STP || d == SDP) begin
        if (m_kind != 0) begin
          e.en = 1; e.len = LW'(m_pay.size()); e.ef = 1;
        end
        e.st = 1;
        m_kind = (d == STP) ? 1 : 2;
        m_pay.delete();
        m_disc = 0;
      end else if (d == ENDK || d == EDB) begin
        if (m_kind == 0) begin
          if (!m_disc) e.ef = 1;
        end else begin
          e.en = 1; e.len = LW'(m_pay.size());
          if (d == ENDK && m_kind == 1) e.gd = 1;
          if (d == ENDK && m_kind == 2) begin
            e.gd = (m_pay.size() == DLLPL);
            e.el = (m_pay.size() != DLLPL);
          end
          if (d == EDB && m_kind == 2) e.ef = 1;
        end
        m_kind = 0; m_disc = 0;
      end else if (d != PAD && m_kind != 0) begin
        e.en = 1; e.len = LW'(m_pay.size()); e.ef = 1;
        m_kind = 0; m_disc = 1;
      end
    end
    e.kind = (e.en && !e.st) ? 2'(closing) : 2'(m_kind);
    if (e.en && e.gd && closing == 1 && m_tlp < CMAX) m_tlp++;
    if (e.en && e.gd && closing == 2 && m_dllp < CMAX) m_dllp++;
    if ((e.ef || e.el) && m_err < CMAX) m_err++;
    if (clr) begin m_tlp = 0; m_dllp = 0; m_err = 0; end
    e.tlp = m_tlp; e.dllp = m_dllp; e.err = m_err;
  endtask

  initial begin
    exp_t z;
    exp_t e;
    logic [7:0] kc[6];
    kc = '{STP, SDP, ENDK, EDB, PAD, UNK};
    z = '{default: '0};

    rst = 1; valid = 0; DK = 0; data_in = 0; stat_clr = 0;
    @(posedge clk); @(posedge clk); #1;
    check_outs("reset", z, 1);
    rst = 0;

    // Directed table: {valid, K, byte, ov, kind, start, end, good, len, errf, errl}
    vq.push_back(mk(1, 1, STP, 0, 2'b01, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h11, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h22, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, PAD, 0, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h33, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h44, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, ENDK, 0, 2'b01, 0, 1, 1, 4, 0, 0));
    vq.push_back(mk(1, 1, SDP, 0, 2'b10, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++) vq.push_back(mk(1, 0, 8'(i), 1, 2'b10, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, ENDK, 0, 2'b10, 0, 1, 1, 6, 0, 0));
    vq.push_back(mk(1, 1, SDP, 0, 2'b10, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 5; i++) vq.push_back(mk(1, 0, 8'(i + 16), 1, 2'b10, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, ENDK, 0, 2'b10, 0, 1, 0, 5, 0, 1));
    vq.push_back(mk(1, 1, STP, 0, 2'b01, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'hAA, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'hBB, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, SDP, 0, 2'b10, 1, 1, 0, 2, 1, 0));
    for (int i = 1; i <= 6; i++) vq.push_back(mk(1, 0, 8'(i + 32), 1, 2'b10, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, ENDK, 0, 2'b10, 0, 1, 1, 6, 0, 0));
    vq.push_back(mk(1, 1, STP, 0, 2'b01, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++) vq.push_back(mk(1, 0, 8'(i + 48), 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h99, 0, 2'b01, 0, 1, 0, 8, 0, 1));
    vq.push_back(mk(1, 1, ENDK, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, ENDK, 0, 2'b00, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, 1, PAD, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h12, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, STP, 0, 2'b01, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h55, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 8'hEE, 0, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, ENDK, 0, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h66, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, EDB, 0, 2'b01, 0, 1, 0, 2, 0, 0));
    vq.push_back(mk(1, 1, STP, 0, 2'b01, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h77, 1, 2'b01, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, UNK, 0, 2'b01, 0, 1, 0, 1, 1, 0));
    vq.push_back(mk(1, 0, 8'h88, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, SDP, 0, 2'b10, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, EDB, 0, 2'b10, 0, 1, 0, 0, 1, 0));

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].k, vq[i].d, 0);
      check_outs($sformatf("vec%0d", i), vq[i].e, 0);
    end
    chk("table.good_tlp_cnt", 32'(good_tlp_cnt), 1);
    chk("table.good_dllp_cnt", 32'(good_dllp_cnt), 2);
    chk("table.err_cnt", 32'(err_cnt), 6);

    // Reset in the middle of a TLP: everything clears, no pkt_end.
    drive(1, 1, STP, 0);
    drive(1, 0, 8'h5A, 0);
    rst = 1;
    drive(1, 1, ENDK, 0);
    check_outs("rst_mid", z, 1);
    rst = 0;
    drive(1, 0, 8'h01, 0);
    check_outs("after_rst", z, 1);

    // Saturation: more good TLPs than the counter can hold.
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(1, 1, STP, 0);
      drive(1, 1, ENDK, 0);
    end
    chk("sat.good_tlp_cnt", 32'(good_tlp_cnt), CMAX);
    chk("sat.pkt_good", 32'(pkt_good), 1);
    drive(1, 1, STP, 0);
    drive(1, 1, ENDK, 1);
    chk("clr_wins.good_tlp_cnt", 32'(good_tlp_cnt), 0);
    chk("clr_wins.pkt_end", 32'(pkt_end), 1);

    // Random phase from a clean reset.
    rst = 1;
    drive(0, 0, 8'h00, 0);
    rst = 0;
    m_kind = 0; m_disc = 0; m_pay.delete();
    m_tlp = 0; m_dllp = 0; m_err = 0;
    for (int n = 0; n < 3000; n++) begin
      logic v, k, clr;
      logic [7:0] d;
      v   = ($urandom_range(0, 9) != 0);
      k   = ($urandom_range(0, 9) < 2);
      d   = k ? kc[$urandom_range(0, 5)] : 8'($urandom_range(0, 255));
      clr = ($urandom_range(0, 99) == 0);
      model(v, k, d, clr, e);
      drive(v, k, d, clr);
      check_outs($sformatf("rnd%0d", n), e, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
